// File: rtl/estagio_assincrono_alu_if.sv
// rtl/estagio_assincrono_alu_if.sv - dual-rail operand/result bus with four-phase handshake
interface estagio_assincrono_alu_if #(
  parameter int WIDTH = 4
);
  logic [2*WIDTH-1:0] a;
  logic [2*WIDTH-1:0] b;
  logic [1:0]         opr;
  logic               ack_in;
  logic [2*WIDTH-1:0] soma;
  logic [1:0]         of;
  logic [1:0]         neg;
  logic [1:0]         zero;
  logic               ack_out;

  modport master (
    output a, b, opr, ack_in,
    input  soma, of, neg, zero, ack_out
  );

  modport slave (
    input  a, b, opr, ack_in,
    output soma, of, neg, zero, ack_out
  );
endinterface

// File: rtl/estagio_assincrono_alu.sv
// rtl/estagio_assincrono_alu.sv - clocked emulation of one NULL-convention dual-rail ALU stage
module estagio_assincrono_alu #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  estagio_assincrono_alu_if.slave bus
);
  typedef enum logic {S_NULL = 1'b0, S_DATA = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               data_ok, null_ok;
  logic [WIDTH-1:0]   a_val, b_val, b_eff, r;
  logic               sub, ovf;
  logic [2*WIDTH-1:0] soma_enc;
  logic [2*WIDTH-1:0] soma_q;
  logic [1:0]         of_q, neg_q, zero_q;

  // Completeness detection and dual-rail to binary decode
  always_comb begin
    data_ok = (bus.opr == 2'b01) || (bus.opr == 2'b10);
    a_val   = '0;
    b_val   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((bus.a[2*i +: 2] != 2'b01) && (bus.a[2*i +: 2] != 2'b10)) data_ok = 1'b0;
      if ((bus.b[2*i +: 2] != 2'b01) && (bus.b[2*i +: 2] != 2'b10)) data_ok = 1'b0;
      a_val[i] = bus.a[2*i+1];
      b_val[i] = bus.b[2*i+1];
    end
    null_ok = (bus.a == '0) && (bus.b == '0) && (bus.opr == 2'b00);
  end

  // Subtraction reuses the adder as A + ~B + 1; overflow compares signs of the effective operands
  always_comb begin
    sub   = bus.opr[1];
    b_eff = sub ? ~b_val : b_val;
    r     = a_val + b_eff + {{(WIDTH-1){1'b0}}, sub};
    ovf   = (a_val[WIDTH-1] == b_eff[WIDTH-1]) && (r[WIDTH-1] != a_val[WIDTH-1]);
    for (int i = 0; i < WIDTH; i++) begin
      soma_enc[2*i +: 2] = r[i] ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NULL:  if (!bus.ack_in && data_ok) state_d = S_DATA;
      S_DATA:  if (bus.ack_in && null_ok)  state_d = S_NULL;
      default: state_d = S_NULL;
    endcase
  end

  // Result registers move only on a state change, so a held wavefront never recomputes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_NULL;
      soma_q  <= '0;
      of_q    <= 2'b00;
      neg_q   <= 2'b00;
      zero_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == S_NULL && state_d == S_DATA) begin
        soma_q <= soma_enc;
        of_q   <= ovf ? 2'b10 : 2'b01;
        neg_q  <= r[WIDTH-1] ? 2'b10 : 2'b01;
        zero_q <= (r == '0) ? 2'b10 : 2'b01;
      end else if (state_q == S_DATA && state_d == S_NULL) begin
        soma_q <= '0;
        of_q   <= 2'b00;
        neg_q  <= 2'b00;
        zero_q <= 2'b00;
      end
    end
  end

  always_comb begin
    bus.ack_out = (state_q == S_DATA);
    bus.soma    = soma_q;
    bus.of      = of_q;
    bus.neg     = neg_q;
    bus.zero    = zero_q;
  end
endmodule

// File: tb/tb_estagio_assincrono_alu.sv
// tb/tb_estagio_assincrono_alu.sv - scoreboard bench for the dual-rail ALU stage
module tb_estagio_assincrono_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  estagio_assincrono_alu_if #(.WIDTH(4)) bus ();

  estagio_assincrono_alu #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {soma, of, neg, zero, ack_out}
  logic [14:0] exp_q[$];
  logic [14:0] cur = '0;
  logic [14:0] act;

  function automatic logic [7:0] enc4(int v);
    logic [7:0] x;
    for (int i = 0; i < 4; i++) x[2*i +: 2] = ((v >> i) & 1) ? 2'b10 : 2'b01;
    return x;
  endfunction

  function automatic logic [1:0] enc1(bit v);
    return v ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [14:0] model(int av, int bv, bit sub);
    int sa, sb, s, r;
    sa = (av >= 8) ? av - 16 : av;
    sb = (bv >= 8) ? bv - 16 : bv;
    s  = sub ? sa - sb : sa + sb;
    r  = (sub ? av - bv : av + bv) & 15;
    return {enc4(r), enc1(s > 7 || s < -8), enc1(r >= 8), enc1(r == 0), 1'b1};
  endfunction

  always @(negedge clk) begin
    act = {bus.soma, bus.of, bus.neg, bus.zero, bus.ack_out};
    if (!rst_n) begin
      exp_q.delete();
      cur = '0;
    end else begin
      if (act[0] != cur[0]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transition act=%h cur=%h", act, cur);
          cur = act;
        end else begin
          cur = exp_q.pop_front();
        end
      end
      checks++;
      if (act !== cur) begin
        errors++;
        $display("FAIL outputs t=%0t act=%h exp=%h", $time, act, cur);
        cur = act;
      end
    end
  end

  task automatic drive(logic [7:0] a, logic [7:0] b, logic [1:0] o, logic ack);
    bus.a = a; bus.b = b; bus.opr = o; bus.ack_in = ack;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic data_wave(logic [7:0] a, logic [7:0] b, logic [1:0] o, logic [14:0] e);
    drive(a, b, o, 1'b0);
    exp_q.push_back(e);
    step();
  endtask

  task automatic null_wave();
    drive(8'h00, 8'h00, 2'b00, 1'b1);
    exp_q.push_back(15'h0);
    step();
  endtask

  task automatic check_zero(string name);
    checks++;
    if ({bus.soma, bus.of, bus.neg, bus.zero, bus.ack_out} !== 15'h0) begin
      errors++;
      $display("FAIL %s act=%h exp=0", name,
               {bus.soma, bus.of, bus.neg, bus.zero, bus.ack_out});
    end
  endtask

  task automatic release_reset();
    drive(8'h00, 8'h00, 2'b00, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  logic [7:0] ta, tb_v;
  logic [1:0] to;
  int av, bv, k, sel;
  bit op;

  initial begin
    drive(8'hFF, 8'h5A, 2'b11, 1'b0);
    step();
    step();
    check_zero("reset_state");
    release_reset();
    step();
    step();

    // Directed cases from the plan
    for (int n = 0; n < 200; n++) begin
      data_wave(8'b01011010, 8'b10101010, 2'b01, {8'b01011001, 2'b01, 2'b01, 2'b01, 1'b1});
      null_wave();
    end
    data_wave(8'b01011010, 8'b01011010, 2'b10, {8'b01010101, 2'b01, 2'b01, 2'b10, 1'b1});
    null_wave();
    data_wave(8'b01101010, 8'b01010110, 2'b01, {8'b10010101, 2'b10, 2'b10, 2'b01, 1'b1});
    null_wave();

    drive(8'b01011010, 8'h00, 2'b01, 1'b0);
    step();
    step();
    drive(8'b11011010, 8'b01010101, 2'b01, 1'b0);
    step();
    drive(8'b01011010, 8'b01010101, 2'b11, 1'b0);
    step();
    data_wave(8'b01011010, 8'b01010101, 2'b01, model(3, 0, 0));
    drive(8'b10101010, 8'b01010101, 2'b10, 1'b0);
    step();
    step();
    drive(8'b00000010, 8'h00, 2'b00, 1'b1);
    step();
    step();
    null_wave();

    // Reset while DATA is held must clear without a clock edge
    data_wave(8'b10101010, 8'b10101010, 2'b01, model(15, 15, 0));
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_data");
    release_reset();

    for (int n = 0; n < 300; n++) begin
      av = $urandom_range(0, 15);
      bv = $urandom_range(0, 15);
      op = 1'($urandom_range(0, 1));
      ta = enc4(av); tb_v = enc4(bv); to = enc1(op);
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 3);
        sel = $urandom_range(0, 2);
        if (sel == 0) drive(ta, tb_v, $urandom_range(0, 1) ? 2'b11 : 2'b00, 1'b0);
        else if (sel == 1) begin
          ta[2*k +: 2] = $urandom_range(0, 1) ? 2'b11 : 2'b00;
          drive(ta, tb_v, to, 1'b0);
        end else begin
          tb_v[2*k +: 2] = $urandom_range(0, 1) ? 2'b11 : 2'b00;
          drive(ta, tb_v, to, 1'b0);
        end
        step();
        ta = enc4(av); tb_v = enc4(bv);
      end
      if ($urandom_range(0, 3) == 0) begin
        drive(ta, tb_v, to, 1'b1);
        step();
      end
      data_wave(ta, tb_v, to, model(av, bv, op));
      for (int h = $urandom_range(0, 2); h > 0; h--) begin
        drive(enc4($urandom_range(0, 15)), tb_v, enc1(1'($urandom_range(0, 1))), 1'b0);
        step();
      end
      if ($urandom_range(0, 2) == 0) begin
        drive(8'h00, 8'h00, 2'b00, 1'b0);
        step();
        drive(8'h00, enc4(bv), 2'b00, 1'b1);
        step();
      end
      null_wave();
    end

    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
